// File: rtl/rv32m_divider.sv
// RV32M DIV/DIVU/REM/REMU unit using radix-2 restoring division, one quotient bit per cycle.
// Latency: 33 cycles from start to done, or 1 cycle for divide-by-zero and signed overflow.
// Backpressure: start is accepted only while idle; busy stalls the pipeline and kill aborts.
module rv32m_divider (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        kill,
    input  logic [1:0]  op,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t      state;
    logic        is_rem;
    logic        neg_q;
    logic        neg_r;
    logic [4:0]  count;
    logic [31:0] q;
    logic [31:0] rem;
    logic [31:0] dvs_r;

    logic        is_signed;
    logic [31:0] dvd_abs;
    logic [31:0] dvs_abs;
    logic        div_zero;
    logic        ovf;
    logic [32:0] trial;

    // 0x80000000 negates to itself, which is exactly its magnitude read as unsigned.
    always_comb begin
        is_signed = ~op[0];
        dvd_abs   = (is_signed && dividend[31]) ? (~dividend + 32'd1) : dividend;
        dvs_abs   = (is_signed && divisor[31])  ? (~divisor + 32'd1)  : divisor;
        div_zero  = (divisor == 32'd0);
        ovf       = is_signed && (dividend == 32'h8000_0000) && (divisor == 32'hFFFF_FFFF);
        trial     = {rem, q[31]} - {1'b0, dvs_r};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            is_rem <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            count  <= 5'd0;
            q      <= 32'd0;
            rem    <= 32'd0;
            dvs_r  <= 32'd0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= 32'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !kill) begin
                        is_rem <= op[1];
                        busy   <= 1'b1;
                        count  <= 5'd0;
                        dvs_r  <= dvs_abs;
                        if (div_zero) begin
                            // Architected results are raw; the sign fixup must not touch them.
                            q     <= 32'hFFFF_FFFF;
                            rem   <= dividend;
                            neg_q <= 1'b0;
                            neg_r <= 1'b0;
                            state <= FIX;
                        end else if (ovf) begin
                            q     <= 32'h8000_0000;
                            rem   <= 32'd0;
                            neg_q <= 1'b0;
                            neg_r <= 1'b0;
                            state <= FIX;
                        end else begin
                            q     <= dvd_abs;
                            rem   <= 32'd0;
                            neg_q <= is_signed & (dividend[31] ^ divisor[31]);
                            neg_r <= is_signed & dividend[31];
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (kill) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        // rem < divisor always holds, so the shifted remainder fits in 33 bits
                        // and the restored or subtracted value fits back into 32.
                        if (!trial[32]) begin
                            rem <= trial[31:0];
                            q   <= {q[30:0], 1'b1};
                        end else begin
                            rem <= {rem[30:0], q[31]};
                            q   <= {q[30:0], 1'b0};
                        end
                        count <= count + 5'd1;
                        if (count == 5'd31) begin
                            state <= FIX;
                        end
                    end
                end
                FIX: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                    if (!kill) begin
                        done <= 1'b1;
                        if (is_rem) begin
                            result <= neg_r ? (~rem + 32'd1) : rem;
                        end else begin
                            result <= neg_q ? (~q + 32'd1) : q;
                        end
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rv32m_divider.sv
// Directed bench for rv32m_divider: results, latency, busy window, ignored start, kill and reset.
module tb_rv32m_divider;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    logic        clk;
    logic        rst;
    logic        start;
    logic        kill;
    logic [1:0]  op;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int checks;
    int failures;

    rv32m_divider dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .kill     (kill),
        .op       (op),
        .dividend (dividend),
        .divisor  (divisor),
        .busy     (busy),
        .done     (done),
        .result   (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge of the done cycle (or after timeout).
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res,
                          input int exp_lat, input int glitch_at);
        int lat;
        int busy_cnt;
        logic busy_at_done;
        lat          = 0;
        busy_cnt     = 0;
        busy_at_done = 1'b1;
        start    = 1'b1;
        op       = o;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        start    = 1'b0;
        op       = ~o;
        dividend = $urandom;
        divisor  = $urandom;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (done) begin
                lat          = i - 1;
                busy_at_done = busy;
                break;
            end
            if (busy) busy_cnt++;
            if (i == glitch_at) begin
                start    = 1'b1;
                op       = OP_DIVU;
                dividend = 32'd50;
                divisor  = 32'd5;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        check({tag, "_result"}, result, exp_res);
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_busy_cycles"}, busy_cnt, exp_lat);
        check({tag, "_busy_at_done"}, {31'd0, busy_at_done}, 32'd0);
    endtask

    // Started in the done cycle of the previous operation; killed at edge kill_at.
    task automatic run_kill(input int kill_at, input logic [31:0] exp_res);
        int done_seen;
        done_seen = 0;
        start    = 1'b1;
        op       = OP_DIVU;
        dividend = 32'd50;
        divisor  = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 1; i <= kill_at; i++) begin
            @(negedge clk);
            if (i == 1) check("b2b_accept_busy", {31'd0, busy}, 32'd1);
            if (done) done_seen++;
            if (i == kill_at) kill = 1'b1;
            @(posedge clk);
            #1;
            kill = 1'b0;
        end
        @(negedge clk);
        check("kill_busy_next", {31'd0, busy}, 32'd0);
        for (int i = 0; i < 40; i++) begin
            if (done) done_seen++;
            @(negedge clk);
        end
        check("kill_no_done", done_seen, 32'd0);
        check("kill_result_kept", result, exp_res);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        start    = 1'b0;
        kill     = 1'b0;
        op       = OP_DIV;
        dividend = 32'd0;
        divisor  = 32'd0;
        #1;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_result", result, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run_op("divu_100_7",   OP_DIVU, 32'd100,        32'd7,          32'd14,         33, 0);
        run_op("remu_100_7",   OP_REMU, 32'd100,        32'd7,          32'd2,          33, 0);
        run_op("div_m7_2",     OP_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  33, 0);
        run_op("rem_m7_2",     OP_REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  33, 0);
        run_op("rem_7_m2",     OP_REM,  32'd7,          32'hFFFF_FFFE,  32'd1,          33, 0);
        run_op("divu_by0",     OP_DIVU, 32'h1234_5678,  32'd0,          32'hFFFF_FFFF,  1,  0);
        run_op("remu_by0",     OP_REMU, 32'h1234_5678,  32'd0,          32'h1234_5678,  1,  0);
        run_op("div_by0",      OP_DIV,  32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFFF,  1,  0);
        run_op("rem_by0",      OP_REM,  32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFF9,  1,  0);
        run_op("div_ovf",      OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1,  0);
        run_op("rem_ovf",      OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1,  0);
        run_op("divu_nofl",    OP_DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          33, 0);
        run_op("remu_nofl",    OP_REMU, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  33, 0);
        run_op("div_min_2",    OP_DIV,  32'h8000_0000,  32'd2,          32'hC000_0000,  33, 0);
        run_op("divu_1000_3",  OP_DIVU, 32'd1000,       32'd3,          32'd333,        33, 5);

        run_kill(10, 32'd333);

        // Asynchronous reset in the middle of CALC.
        start    = 1'b1;
        op       = OP_DIVU;
        dividend = 32'd77;
        divisor  = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_done", {31'd0, done}, 32'd0);
        check("arst_result", result, 32'd0);
        #1;
        rst = 1'b0;
        @(negedge clk);
        run_op("divu_9_3_after_rst", OP_DIVU, 32'd9, 32'd3, 32'd3, 33, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
